// File: rtl/rgb2gray_pkg.sv
// rgb2gray_pkg: conversion modes and fixed-point channel weights shared by the grayscale pipeline.
package rgb2gray_pkg;
  localparam int COEF_FRAC_DEF = 8;
  localparam int WEIGHT_W = 9;
  typedef enum logic [1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_MAX   = 2'd3
  } mode_e;
  typedef struct packed {
    logic [WEIGHT_W-1:0] r;
    logic [WEIGHT_W-1:0] g;
    logic [WEIGHT_W-1:0] b;
  } weights_t;
  // Weights sum to 256 so full-scale white maps to full-scale gray; MODE_MAX ignores them.
  function automatic weights_t mode_weights(input mode_e m);
    return m == MODE_BT601 ? {9'd77, 9'd150, 9'd29} :
           m == MODE_BT709 ? {9'd54, 9'd183, 9'd19} :
           m == MODE_AVG   ? {9'd85, 9'd85,  9'd86} : '0;
  endfunction
endpackage

// File: rtl/gray_frame_counter.sv
// gray_frame_counter: counts output handshakes and flags the pixel that completes a frame.
module gray_frame_counter #(
  parameter int FRAME_PIXELS = 307200
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic hs_i,
  input  logic valid_i,
  output logic frame_done_o
);
  localparam int CW = $clog2(FRAME_PIXELS + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic fd_q, fd_d;
  // A pixel entering the output stage is the last of a frame when the count after this edge is FRAME_PIXELS-1.
  always_comb begin
    cnt_inc = cnt_q + CW'(1);
    cnt_d = !hs_i ? cnt_q : (cnt_inc == CW'(FRAME_PIXELS) ? '0 : cnt_inc);
    fd_d = en_i ? (valid_i && cnt_d == CW'(FRAME_PIXELS - 1)) : fd_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      fd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fd_q <= fd_d;
    end
  end
  assign frame_done_o = fd_q;
endmodule

// File: rtl/rgb2gray_pipe.sv
// rgb2gray_pipe: three-stage RGB to grayscale converter with per-pixel mode and frame marking.
module rgb2gray_pipe
  import rgb2gray_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_FRAC = COEF_FRAC_DEF,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] red_i,
  input  logic [DATA_WIDTH-1:0] green_i,
  input  logic [DATA_WIDTH-1:0] blue_i,
  input  logic                  done_i,
  input  logic [1:0]            mode_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] grayscale_o,
  output logic                  done_o,
  input  logic                  ready_i,
  output logic                  frame_done_o
);
  localparam int PW = DATA_WIDTH + WEIGHT_W;
  localparam int SW = PW + 2;
  logic en;
  weights_t w;
  logic [DATA_WIDTH-1:0] mx_rg, mx_d, mx_q, gray_d, gray_q;
  logic [PW-1:0] pr_q, pg_q, pb_q;
  logic [SW-1:0] sum_d, sum_q, shifted;
  logic v1_q, v2_q, done_q;
  mode_e mode1_q;
  assign en = ready_i | ~done_q;
  assign ready_o = en;
  assign w = mode_weights(mode_e'(mode_i));
  // Max mode rides the same pipe: its value is pre-scaled so the rounding shift returns it unchanged.
  always_comb begin
    mx_rg = red_i > green_i ? red_i : green_i;
    mx_d = mx_rg > blue_i ? mx_rg : blue_i;
    sum_d = mode1_q == MODE_MAX ? SW'(mx_q) << COEF_FRAC :
            SW'(pr_q) + SW'(pg_q) + SW'(pb_q) + (SW'(1) << (COEF_FRAC - 1));
    shifted = sum_q >> COEF_FRAC;
    gray_d = |shifted[SW-1:DATA_WIDTH] ? '1 : shifted[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      done_q <= 1'b0;
      mode1_q <= MODE_BT601;
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
      mx_q <= '0;
      sum_q <= '0;
      gray_q <= '0;
    end else if (en) begin
      v1_q <= done_i;
      mode1_q <= mode_e'(mode_i);
      pr_q <= PW'(red_i) * PW'(w.r);
      pg_q <= PW'(green_i) * PW'(w.g);
      pb_q <= PW'(blue_i) * PW'(w.b);
      mx_q <= mx_d;
      v2_q <= v1_q;
      sum_q <= sum_d;
      done_q <= v2_q;
      gray_q <= gray_d;
    end
  end
  assign done_o = done_q;
  assign grayscale_o = gray_q;
  gray_frame_counter #(.FRAME_PIXELS(FRAME_PIXELS)) u_frame_counter (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .hs_i         (done_q & ready_i),
    .valid_i      (v2_q),
    .frame_done_o (frame_done_o)
  );
endmodule

// File: tb/tb_rgb2gray_pipe.sv
// tb_rgb2gray_pipe: directed vectors with hand-computed gray values, stall, framing and reset scenarios.
module tb_rgb2gray_pipe;
  logic clk = 1'b0;
  logic rst, done_i, ready_i, ready_o, done_o, frame_done_o;
  logic [1:0] mode_i;
  logic [7:0] red_i, green_i, blue_i, grayscale_o;
  int total = 0, bad = 0, n_out = 0, out_idx = 0, fd_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] t3r[6] = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0};
  logic [7:0] t3g[6] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0};
  logic [7:0] t3b[6] = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
  logic [1:0] t3m[6] = '{2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1};
  logic [7:0] t3e[6] = '{8'd255, 8'd29, 8'd149, 8'd85, 8'd86, 8'd19};
  always #5 clk = ~clk;
  rgb2gray_pipe #(.DATA_WIDTH(8), .COEF_FRAC(8), .FRAME_PIXELS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .red_i        (red_i),
    .green_i      (green_i),
    .blue_i       (blue_i),
    .done_i       (done_i),
    .mode_i       (mode_i),
    .ready_o      (ready_o),
    .grayscale_o  (grayscale_o),
    .done_o       (done_o),
    .ready_i      (ready_i),
    .frame_done_o (frame_done_o)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [1:0] m, input logic [7:0] e);
    red_i = r;
    green_i = g;
    blue_i = b;
    mode_i = m;
    done_i = 1'b1;
    exp_q.push_back(e);
    tick();
  endtask
  task automatic do_reset;
    rst = 1'b0;
    done_i = 1'b0;
    exp_q.delete();
    out_idx = 0;
    n_out = 0;
    fd_count = 0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  // Output scoreboard: every handshake must match the next expected pixel and its frame position.
  always @(negedge clk) begin
    if (done_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_out", 32'(done_o), 32'd0);
      else begin
        chk("out_gray", 32'(grayscale_o), 32'(exp_q.pop_front()));
        chk("out_frame_done", 32'(frame_done_o), 32'(out_idx % 16 == 15));
      end
      if (frame_done_o) fd_count++;
      out_idx++;
      n_out++;
    end
  end
  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int idx, stalls;
    logic acc;
    rst = 1'b0;
    done_i = 1'b0;
    ready_i = 1'b1;
    mode_i = 2'd0;
    red_i = '0;
    green_i = '0;
    blue_i = '0;
    tick();
    tick();
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_gray", 32'(grayscale_o), 32'd0);
    chk("rst_frame_done", 32'(frame_done_o), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(ready_o), 32'd1);
    send(8'd200, 8'd200, 8'd200, 2'd0, 8'd200);
    done_i = 1'b0;
    chk("t1_lat0", 32'(done_o), 32'd0);
    tick();
    chk("t1_lat1", 32'(done_o), 32'd0);
    tick();
    chk("t1_lat2_done", 32'(done_o), 32'd1);
    chk("t1_lat2_gray", 32'(grayscale_o), 32'd200);
    send(8'd255, 8'd0, 8'd0, 2'd0, 8'd77);
    done_i = 1'b0;
    tick();
    tick();
    chk("t1_red_done", 32'(done_o), 32'd1);
    chk("t1_red_gray", 32'(grayscale_o), 32'd77);
    tick();
    send(8'd0, 8'd255, 8'd0, 2'd1, 8'd182);
    send(8'd10, 8'd20, 8'd30, 2'd2, 8'd20);
    send(8'd10, 8'd200, 8'd30, 2'd3, 8'd200);
    done_i = 1'b0;
    chk("t2_bt709", 32'(grayscale_o), 32'd182);
    tick();
    chk("t2_avg", 32'(grayscale_o), 32'd20);
    chk("t2_avg_done", 32'(done_o), 32'd1);
    tick();
    chk("t2_max", 32'(grayscale_o), 32'd200);
    chk("t2_max_done", 32'(done_o), 32'd1);
    tick();
    chk("t2_idle", 32'(done_o), 32'd0);
    idx = 0;
    stalls = 0;
    for (int c = 0; c < 60 && (idx < 6 || exp_q.size() > 0); c++) begin
      if (done_o && stalls < 5) begin
        ready_i = 1'b0;
        stalls++;
      end else ready_i = 1'b1;
      done_i = idx < 6;
      if (idx < 6) begin
        red_i = t3r[idx];
        green_i = t3g[idx];
        blue_i = t3b[idx];
        mode_i = t3m[idx];
      end
      @(negedge clk);
      acc = done_i && ready_o;
      if (!ready_i) begin
        chk("t3_stall_ready", 32'(ready_o), 32'd0);
        chk("t3_stall_gray", 32'(grayscale_o), 32'd255);
        chk("t3_stall_done", 32'(done_o), 32'd1);
      end
      if (acc) exp_q.push_back(t3e[idx]);
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    done_i = 1'b0;
    ready_i = 1'b1;
    chk("t3_stall_cycles", 32'(stalls), 32'd5);
    chk("t3_count", 32'(n_out), 32'd11);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    do_reset();
    for (int i = 0; i < 32; i++) send(8'(i * 7 + 3), 8'(i * 7 + 3), 8'(i * 7 + 3), 2'd0, 8'(i * 7 + 3));
    done_i = 1'b0;
    repeat (4) tick();
    chk("t4_count", 32'(n_out), 32'd32);
    chk("t4_frame_pulses", 32'(fd_count), 32'd2);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    send(8'd10, 8'd10, 8'd10, 2'd0, 8'd10);
    send(8'd20, 8'd20, 8'd20, 2'd0, 8'd20);
    send(8'd30, 8'd30, 8'd30, 2'd0, 8'd30);
    rst = 1'b0;
    done_i = 1'b0;
    exp_q.delete();
    out_idx = 0;
    n_out = 0;
    fd_count = 0;
    #1;
    chk("t5_async_done", 32'(done_o), 32'd0);
    chk("t5_async_gray", 32'(grayscale_o), 32'd0);
    chk("t5_async_frame_done", 32'(frame_done_o), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_rel_ready", 32'(ready_o), 32'd1);
    repeat (3) begin
      tick();
      chk("t5_no_stale", 32'(done_o), 32'd0);
    end
    for (int i = 0; i < 16; i++) send(8'(i * 11), 8'(i * 11), 8'(i * 11), 2'd0, 8'(i * 11));
    done_i = 1'b0;
    repeat (4) tick();
    chk("t5_count", 32'(n_out), 32'd16);
    chk("t5_frame_pulses", 32'(fd_count), 32'd1);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rgb2gray_pipe.md
RGB2GRAY_PIPE -- requirements
Module: rgb2gray_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of each colour channel and of the gray output.
REQ-002 SHALL have parameter COEF_FRAC, default 8: fractional bits of the fixed-point weights.
REQ-003 SHALL have parameter FRAME_PIXELS, default 307200: number of output pixels per frame.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have ports red_i, green_i, blue_i, input, DATA_WIDTH bits each: input pixel channels.
REQ-007 SHALL have port done_i, input, 1 bit: input pixel valid.
REQ-008 SHALL have port mode_i, input, 2 bits: conversion mode, sampled with each accepted pixel.
REQ-009 SHALL have port ready_o, output, 1 bit: block can accept a pixel this cycle.
REQ-010 SHALL have port grayscale_o, output, DATA_WIDTH bits: converted pixel.
REQ-011 SHALL have port done_o, output, 1 bit: grayscale_o valid.
REQ-012 SHALL have port ready_i, input, 1 bit: downstream accepts the output.
REQ-013 SHALL have port frame_done_o, output, 1 bit: asserted alongside the last output pixel of a frame.

Function
REQ-014 SHALL accept a pixel on a rising edge where done_i=1 and ready_o=1; all other input cycles SHALL be ignored.
REQ-015 SHALL implement a 3-stage pipeline:
  - S1 registers the three weighted products.
  - S2 registers the rounded sum.
  - S3 registers grayscale_o, done_o and frame_done_o.
REQ-016 SHALL compute pipeline enable en = ready_i OR NOT done_o; ready_o SHALL equal en (combinational).
REQ-017 SHALL advance all stages, with their valid bits, together when en=1, and SHALL hold every stage when en=0.
REQ-018 SHALL produce the output immediately after edge k+2 for a pixel accepted at edge k with no stall (latency 3 registers). Each stall cycle SHALL add exactly one cycle.
REQ-019 SHALL use the following weights, scaled by 2^COEF_FRAC with COEF_FRAC=8, and carry the mode per pixel through the pipeline:
  - mode 0 (BT.601): R, G, B weights 77, 150, 29.
  - mode 1 (BT.709): R, G, B weights 54, 183, 19.
  - mode 2 (average): R, G, B weights 85, 85, 86.
  - mode 3: max(R,G,B), which bypasses the weights with the same latency.
REQ-020 SHALL compute gray = (sum of products + 2^(COEF_FRAC-1)) >> COEF_FRAC, using a sum wide enough for no overflow, and saturate the result to 2^DATA_WIDTH-1.
REQ-021 SHALL allow a mode_i change between consecutive pixels, with each pixel converted in its own mode and no bubble inserted.
REQ-022 SHALL keep grayscale_o and done_o stable while done_o=1 and ready_i=0.
REQ-023 SHALL increment the frame pixel counter on each output handshake (done_o=1 and ready_i=1).
REQ-024 SHALL assert frame_done_o together with the output pixel whose handshake makes the count FRAME_PIXELS. On that handshake the counter SHALL wrap to 0.
REQ-025 SHALL keep pixel order and lose or duplicate no pixel under any ready_i pattern; the internal capacity is 3 pixels.

Reset
REQ-026 SHALL, while rst=0, asynchronously clear all stage valids, done_o, frame_done_o and the pixel counter, and force grayscale_o to 0.
REQ-027 SHALL discard any in-flight pixels on reset mid-stream, and the next frame count SHALL start from 0.
REQ-028 SHALL drive ready_o=1 in the first cycle after rst releases, since done_o=0.

Structure
REQ-029 SHALL place the mode encodings, the weight table per mode and the COEF_FRAC default in shared package rgb2gray_pkg.
REQ-030 SHALL implement the pixel counter and frame_done generation as sub-module gray_frame_counter, parameterised by FRAME_PIXELS.

Verification
REQ-031 SHALL cover mode 0 with ready_i=1:
  - (200,200,200) -> 200.
  - (255,0,0) -> 77.
  - Each result appears 3 cycles after acceptance.
REQ-032 SHALL cover mode switching on back-to-back pixels:
  - mode 1 (0,255,0) -> 182.
  - mode 2 (10,20,30) -> 20.
  - mode 3 (10,200,30) -> 200.
  - Results appear in order on consecutive cycles.
REQ-033 SHALL cover backpressure: a stream of 6 pixels with ready_i=0 for 5 cycles after the first output.
  - ready_o falls once the pipe is full.
  - All 6 outputs arrive in order with no loss.
  - grayscale_o stays stable while stalled.
REQ-034 SHALL cover framing with FRAME_PIXELS=16 and 32 pixels streamed: frame_done_o pulses exactly with output 16 and output 32.
REQ-035 SHALL cover reset mid-stream: rst=0 with 2 pixels in flight.
  - done_o drops to 0 immediately.
  - No stale output follows.
  - The next 16 pixels produce frame_done_o on the 16th.
